// File: rtl/pipelined_datapath.sv
// Two-stage datapath: operand read/latch (RD) then ALU (EX) with registered write-back.
// Flop-based register file with hardwired r0, EX-to-RD forwarding and output-stall flow control.
module pipelined_datapath #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int PTR_W      = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op,
    input  logic                  write_en,
    input  logic [PTR_W-1:0]      write_ptr,
    input  logic [PTR_W-1:0]      read_a_ptr,
    input  logic [PTR_W-1:0]      read_b_ptr,
    input  logic                  out_ready,
    output logic                  result_valid,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero,
    output logic                  carry
);
    localparam int SH_W = $clog2(DATA_WIDTH);
    localparam logic [DATA_WIDTH:0] ONE = {{DATA_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_SLL  = 3'd5,
        OP_SRL  = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic                  ex_valid_q, ex_valid_d;
    logic                  ex_we_q, ex_we_d;
    logic [PTR_W-1:0]      ex_wp_q, ex_wp_d;
    op_e                   ex_op_q, ex_op_d;
    logic [DATA_WIDTH-1:0] ex_a_q, ex_a_d;
    logic [DATA_WIDTH-1:0] ex_b_q, ex_b_d;

    logic                  rv_q, rv_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  zero_q, zero_d;
    logic                  carry_q, carry_d;

    logic                  stall;
    logic                  accept;
    logic                  wb_en;
    logic                  ex_fwd_ok;
    logic [DATA_WIDTH:0]   alu_full;
    logic                  alu_carry;
    logic [DATA_WIDTH-1:0] alu_y;
    logic [DATA_WIDTH-1:0] rd_a, rd_b;

    assign stall     = rv_q && !out_ready;
    assign in_ready  = !stall;
    assign accept    = in_valid && in_ready;
    assign wb_en     = ex_valid_q && !stall;
    assign ex_fwd_ok = ex_valid_q && ex_we_q && (ex_wp_q != '0);

    // SUB is a + ~b + 1 so the top bit is directly "not borrow" (a >= b unsigned).
    always_comb begin
        alu_full  = '0;
        alu_carry = 1'b0;
        unique case (ex_op_q)
            OP_ADD: begin
                alu_full  = {1'b0, ex_a_q} + {1'b0, ex_b_q};
                alu_carry = alu_full[DATA_WIDTH];
            end
            OP_SUB: begin
                alu_full  = {1'b0, ex_a_q} + {1'b0, ~ex_b_q} + ONE;
                alu_carry = alu_full[DATA_WIDTH];
            end
            OP_AND:  alu_full = {1'b0, ex_a_q & ex_b_q};
            OP_OR:   alu_full = {1'b0, ex_a_q | ex_b_q};
            OP_XOR:  alu_full = {1'b0, ex_a_q ^ ex_b_q};
            OP_SLL:  alu_full = {1'b0, ex_a_q << ex_b_q[SH_W-1:0]};
            OP_SRL:  alu_full = {1'b0, ex_a_q >> ex_b_q[SH_W-1:0]};
            OP_PASS: alu_full = {1'b0, ex_a_q};
            default: alu_full = '0;
        endcase
    end

    assign alu_y = alu_full[DATA_WIDTH-1:0];

    always_comb begin
        rd_a = (read_a_ptr == '0) ? '0 : regs_q[read_a_ptr];
        rd_b = (read_b_ptr == '0) ? '0 : regs_q[read_b_ptr];
        if (ex_fwd_ok && (ex_wp_q == read_a_ptr)) rd_a = alu_y;
        if (ex_fwd_ok && (ex_wp_q == read_b_ptr)) rd_b = alu_y;
    end

    always_comb begin
        regs_d     = regs_q;
        ex_valid_d = ex_valid_q;
        ex_we_d    = ex_we_q;
        ex_wp_d    = ex_wp_q;
        ex_op_d    = ex_op_q;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        rv_d       = rv_q;
        result_d   = result_q;
        zero_d     = zero_q;
        carry_d    = carry_q;

        if (!stall) begin
            ex_valid_d = accept;
            if (accept) begin
                ex_we_d = write_en;
                ex_wp_d = write_ptr;
                ex_op_d = op_e'(op);
                ex_a_d  = rd_a;
                ex_b_d  = rd_b;
            end
        end

        if (wb_en) begin
            result_d = alu_y;
            zero_d   = (alu_y == '0);
            carry_d  = alu_carry;
            rv_d     = 1'b1;
            if (ex_we_q && (ex_wp_q != '0)) regs_d[ex_wp_q] = alu_y;
        end else if (out_ready) begin
            rv_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q     <= '{default: '0};
            ex_valid_q <= 1'b0;
            ex_we_q    <= 1'b0;
            ex_wp_q    <= '0;
            ex_op_q    <= OP_ADD;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            rv_q       <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            ex_valid_q <= ex_valid_d;
            ex_we_q    <= ex_we_d;
            ex_wp_q    <= ex_wp_d;
            ex_op_q    <= ex_op_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            rv_q       <= rv_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
        end
    end

    assign result_valid = rv_q;
    assign result       = result_q;
    assign zero         = zero_q;
    assign carry        = carry_q;

endmodule

// File: tb/tb_pipelined_datapath.sv
// Randomized bench for pipelined_datapath: architectural (program-order) model plus a
// result scoreboard with arrival timing derived from the accept/consume history.
module tb_pipelined_datapath;
    localparam int DW = 32;
    localparam int NR = 32;
    localparam int PW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    op = '0;
    logic          write_en = 1'b0;
    logic [PW-1:0] write_ptr = '0;
    logic [PW-1:0] read_a_ptr = '0;
    logic [PW-1:0] read_b_ptr = '0;
    logic          out_ready = 1'b1;
    logic          result_valid;
    logic [DW-1:0] result;
    logic          zero;
    logic          carry;

    always #5 clk = ~clk;

    pipelined_datapath #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .write_en(write_en), .write_ptr(write_ptr), .read_a_ptr(read_a_ptr),
        .read_b_ptr(read_b_ptr), .out_ready(out_ready), .result_valid(result_valid),
        .result(result), .zero(zero), .carry(carry)
    );

    typedef struct packed {
        logic [DW-1:0] r;
        logic          z;
        logic          c;
        int            k;
    } exp_t;

    int unsigned   n_tests = 0;
    int unsigned   n_fail = 0;
    logic [DW-1:0] mregs [NR];
    exp_t          expq[$];
    int            now = 0;
    int            last_cons = -10;
    logic [DW-1:0] bd_val;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, now);
        end
    endtask

    function automatic exp_t alu_model(input logic [2:0] o, input logic [DW-1:0] a,
                                       input logic [DW-1:0] b, input int k);
        exp_t e;
        logic [63:0] wide;
        e.c = 1'b0;
        case (o)
            3'd0: begin
                wide = 64'(a) + 64'(b);
                e.r  = a + b;
                e.c  = (wide >= (64'd1 << DW));
            end
            3'd1: begin
                e.r = a - b;
                e.c = (a >= b);
            end
            3'd2: e.r = a & b;
            3'd3: e.r = a | b;
            3'd4: e.r = a ^ b;
            3'd5: e.r = a << int'(b % DW);
            3'd6: e.r = a >> int'(b % DW);
            default: e.r = a;
        endcase
        e.z = (e.r == '0);
        e.k = k;
        return e;
    endfunction

    // One clock cycle: drive at negedge, check outputs, then model what the coming edge does.
    task automatic cyc(input bit v, input logic [2:0] o, input bit we, input logic [PW-1:0] wp,
                       input logic [PW-1:0] ra, input logic [PW-1:0] rb, input bit ordy,
                       output bit acc);
        bit   exp_rv;
        bit   exp_ir;
        int   arr;
        exp_t e;
        @(negedge clk);
        in_valid = v; op = o; write_en = we; write_ptr = wp;
        read_a_ptr = ra; read_b_ptr = rb; out_ready = ordy;
        #1;
        exp_rv = 1'b0;
        if (expq.size() > 0) begin
            arr = (expq[0].k + 2 > last_cons + 1) ? expq[0].k + 2 : last_cons + 1;
            exp_rv = (now >= arr);
        end
        exp_ir = !(exp_rv && !ordy);
        check("result_valid", 64'(result_valid), 64'(exp_rv));
        check("in_ready", 64'(in_ready), 64'(exp_ir));
        if (exp_rv && ordy) begin
            check("result", 64'(result), 64'(expq[0].r));
            check("zero", 64'(zero), 64'(expq[0].z));
            check("carry", 64'(carry), 64'(expq[0].c));
            void'(expq.pop_front());
            last_cons = now;
        end
        acc = 1'b0;
        if (v && exp_ir) begin
            e = alu_model(o, (ra == 0) ? '0 : mregs[ra], (rb == 0) ? '0 : mregs[rb], now);
            if (we && wp != 0) mregs[wp] = e.r;
            expq.push_back(e);
            acc = 1'b1;
        end
        now++;
    endtask

    task automatic issue(input logic [2:0] o, input bit we, input logic [PW-1:0] wp,
                         input logic [PW-1:0] ra, input logic [PW-1:0] rb);
        bit acc = 1'b0;
        int tries = 0;
        while (!acc && tries < 20) begin
            cyc(1'b1, o, we, wp, ra, rb, 1'b1, acc);
            tries++;
        end
        if (!acc) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 1'b0, '0, '0, '0, 1'b1, acc);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n = 1'b0; in_valid = 1'b1; op = 3'd0; write_en = 1'b1;
            write_ptr = 5'd5; read_a_ptr = 5'd1; read_b_ptr = 5'd2;
            out_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        expq.delete();
        for (int i = 0; i < NR; i++) mregs[i] = '0;
        #1;
        check("rst_result_valid", 64'(result_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_zero", 64'(zero), 64'd0);
        check("rst_carry", 64'(carry), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        now++;
    endtask

    // Bench-only register load: issue a write to r and override the ALU output for its write-back.
    task backdoor(input logic [PW-1:0] r, input logic [DW-1:0] v);
        @(negedge clk);
        in_valid = 1'b1; op = 3'd0; write_en = 1'b1; write_ptr = r;
        read_a_ptr = '0; read_b_ptr = '0; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        bd_val = v;
        force dut.alu_y = bd_val;
        @(negedge clk);
        release dut.alu_y;
        out_ready = 1'b1;
        mregs[r] = v;
        now += 3;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [2:0]    s_op [3];
        logic [PW-1:0] s_wp [3];
        logic [PW-1:0] s_ra [3];
        logic [PW-1:0] s_rb [3];
        int  stall_left;
        bit  acc;
        int  tries;

        for (int i = 0; i < NR; i++) mregs[i] = '0;

        do_reset(2);
        issue(3'd0, 1'b1, 5'd3, 5'd1, 5'd2);
        idle(3);

        backdoor(5'd1, 32'd5);
        backdoor(5'd2, 32'd7);
        issue(3'd0, 1'b1, 5'd3, 5'd1, 5'd2);
        issue(3'd1, 1'b1, 5'd4, 5'd3, 5'd1);
        issue(3'd1, 1'b1, 5'd9, 5'd1, 5'd2);
        issue(3'd4, 1'b1, 5'd10, 5'd1, 5'd1);
        issue(3'd0, 1'b1, 5'd0, 5'd1, 5'd2);
        issue(3'd7, 1'b1, 5'd11, 5'd0, 5'd0);
        idle(3);

        s_op = '{3'd0, 3'd1, 3'd3};
        s_wp = '{5'd6, 5'd7, 5'd8};
        s_ra = '{5'd1, 5'd6, 5'd6};
        s_rb = '{5'd2, 5'd1, 5'd7};
        stall_left = 3;
        for (int i = 0; i < 3; i++) begin
            acc = 1'b0;
            tries = 0;
            while (!acc && tries < 20) begin
                cyc(1'b1, s_op[i], 1'b1, s_wp[i], s_ra[i], s_rb[i], stall_left == 0, acc);
                if (stall_left > 0) stall_left--;
                tries++;
            end
            if (!acc) check("stall_accept_timeout", 64'd0, 64'd1);
        end
        issue(3'd7, 1'b0, 5'd0, 5'd6, 5'd0);
        issue(3'd7, 1'b0, 5'd0, 5'd7, 5'd0);
        issue(3'd7, 1'b0, 5'd0, 5'd8, 5'd0);
        issue(3'd7, 1'b0, 5'd0, 5'd1, 5'd0);
        idle(3);

        issue(3'd0, 1'b1, 5'd5, 5'd1, 5'd2);
        do_reset(1);
        idle(2);
        issue(3'd7, 1'b0, 5'd0, 5'd5, 5'd0);
        idle(3);

        for (int r = 1; r <= 4; r++) backdoor(PW'(r), DW'($urandom));
        for (int i = 0; i < 300; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), PW'($urandom_range(0, 7)),
                PW'($urandom_range(0, 7)), PW'($urandom_range(0, 7)),
                1'($urandom_range(0, 3) != 0), acc);
        end
        idle(8);
        check("drain_empty", 64'(expq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pipelined_datapath.md
# pipelined_datapath

Parametrised two-stage CPU datapath: a register file, an operand-latch stage, and an ALU with registered write-back. It adds operand forwarding, valid/ready flow control, an output stall, a hardwired zero register and a carry flag. Instructions are issued by the control unit, one per accepted cycle. Results are written back to the register file and presented on `result` to downstream logic.

## Interface
- `DATA_WIDTH`, 32: ALU and register width; must be ≥ 8 and a power of two.
- `NUM_REGS`, 32: register count; must be a power of two, ≥ 2.
- `PTR_W`, $clog2(NUM_REGS): register pointer width; derived, not overridden.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: the instruction fields below are valid.
- `in_ready` out 1: the datapath can accept an instruction this cycle.
- `op` in 3: ALU operation; 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 PASS_A.
- `write_en` in 1: write the result back to `write_ptr`.
- `write_ptr` in PTR_W: destination register.
- `read_a_ptr` in PTR_W: source register for operand A.
- `read_b_ptr` in PTR_W: source register for operand B.
- `out_ready` in 1: the consumer takes `result` this cycle.
- `result_valid` out 1: `result`, `zero` and `carry` are valid.
- `result` out DATA_WIDTH: registered ALU result.
- `zero` out 1: set when `result == 0`.
- `carry` out 1: carry-out for ADD; NOT borrow for SUB (1 when a ≥ b unsigned); 0 for all other ops.

## Operation
- **Accept.** An instruction is accepted when `in_valid && in_ready`.
  - `stall = result_valid && !out_ready`.
  - `in_ready = !stall`.
- **Stage RD (accept cycle).** Operands are read combinationally.
  - Register 0 always reads 0.
  - Forwarding: if the EX stage holds a valid instruction with `write_en=1`, its `write_ptr` ≠ 0, and `write_ptr` matches a source pointer, that operand comes from the EX ALU output instead of the register file.
  - A, B, op, write_en and write_ptr are latched into the EX registers at the edge; EX becomes valid.
- **Stage EX.** The ALU operates on the latched operands.
  - ADD/SUB: DATA_WIDTH+1-bit arithmetic; the top bit gives `carry`.
  - SLL/SRL: shift A by `B[$clog2(DATA_WIDTH)-1:0]`, logical, zero fill.
  - PASS_A: result = A.
- **Write-back.** At the edge when EX is valid and `!stall`:
  - the ALU output, `zero` and `carry` load into the output registers;
  - `result_valid` is set to 1;
  - if `write_en` is set and `write_ptr` ≠ 0, the register file is written at the same edge.
  - Writes to register 0 are discarded.
- **Output clear.** `result_valid` clears at an edge where `out_ready=1` and no new EX result is loading.
- **Stall.** While `stall` is high, the EX registers, output registers and register file hold, and no write occurs. Forwarding from the held EX instruction remains active.
- **Reset.** When `rst_n=0` at an edge:
  - all registers 0..NUM_REGS-1 clear to 0;
  - the EX stage is invalidated;
  - `result_valid=0`, `result=0`, `zero=0`, `carry=0`.
  - In-flight instructions are discarded with no register file write.
  - `in_ready` is 1 in the first cycle after reset.
- **Write/read conflict.** A register file write and a read of the same register in the same cycle return the old value. This case is covered by EX forwarding, since the writer is in EX during that cycle.

## Timing
- Latency: an instruction accepted in cycle t shows `result_valid=1` with its result in cycle t+2.
- Throughput: one instruction per cycle while `out_ready=1`.
- Back-to-back dependency: an instruction in cycle t+1 sourcing the destination of the instruction in cycle t gets the forwarded value with no bubble.
- Dependency two cycles later (cycle t+2) reads the register file, already written at the end of t+1.
- `in_ready` is combinational from `result_valid` and `out_ready`. There is no combinational path from `in_valid` to `in_ready`.
- Outputs are registered; `result`, `zero` and `carry` change only at an edge where a new result loads or reset occurs.
- The register file is built from flops (not RAM) so that a synchronous clear is possible.

## Test plan
- **Reset:** hold `rst_n=0` for 2 cycles with `in_valid=1` -> `result_valid=0`, `result=0`, `zero=0`, `carry=0`, `in_ready=1` after release; reading r1 and r2 with ADD gives 0 with `zero=1`.
- **Forwarding:** the default configuration has no immediate path, so the bench cannot load a non-zero value by instruction alone. Use a bench-only backdoor write: r1=5, r2=7. Then issue ADD r3=r1+r2 followed immediately by SUB r4=r3-r1 -> results 12, then 7, in consecutive cycles; SUB `carry=1`.
- **Borrow and zero:** SUB with r1=5, r2=7 -> result 0xFFFFFFFE, `carry=0`, `zero=0`. XOR r1,r1 -> 0 with `zero=1`.
- **Register 0:** ADD with r0 as destination, then PASS_A reading r0 -> result 0, and no forwarding of the discarded value.
- **Stall:** hold `out_ready=0` for 3 cycles with a stream of 3 instructions -> `in_ready=0` while stalled; results are delivered in order with none lost or duplicated; no extra register file write occurs.
- **Reset mid-flight:** assert `rst_n=0` while an ADD to r5 is in EX -> r5 reads 0 afterwards and `result_valid` stays 0.
